// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader:
//               FSM state encoding and the number of bytes per memory word.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM states; explicit 3-bit encoding so the state register width
    // is fixed regardless of tool defaults.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs a byte stream into 32-bit words, little-endian. The
//               first byte of a word ends in bits 7:0, the last in 31:24.
//               last_byte flags that the next accepted byte completes a word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;

    // Next-state for the shift register and byte counter. New bytes enter at
    // the top, so after four shifts the first byte sits in bits 7:0. The
    // 2-bit counter wraps naturally back to 0 on the fourth byte.
    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            shift_d    = 32'h0;
            byte_cnt_d = 2'd0;
        end else if (shift_en) begin
            shift_d    = {byte_in, shift_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    // Assembly state registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= 32'h0;
            byte_cnt_q <= 2'd0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word      = shift_q;
    assign last_byte = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a byte stream, packs it into 32-bit words and writes
//               them to instruction memory from address 0 upward, holding the
//               core in reset until the requested number of words is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] n_words,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_reset
);

    localparam logic [31:0] SIZE_U = 32'(SIZE);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;

    logic        asm_clear;
    logic        asm_shift;
    logic [31:0] asm_word;
    logic        asm_last;
    logic        start_ok;
    logic [16:0] word_idx_inc;

    assign start_ok     = (n_words != 16'd0) && ({16'h0, n_words} <= SIZE_U);
    assign word_idx_inc = {1'b0, word_idx_q} + 17'd1;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (in_data),
        .word      (asm_word),
        .last_byte (asm_last)
    );

    // Next-state logic: session start/validation, byte acceptance, and the
    // single-cycle write that advances the word index.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    asm_clear  = 1'b1;
                    count_d    = n_words;
                    word_idx_d = 16'd0;
                    state_d    = start_ok ? ST_RECV : ST_ERR;
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    asm_shift = 1'b1;
                    if (asm_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_inc[15:0];
                state_d    = (word_idx_inc == {1'b0, count_q}) ? ST_DONE : ST_RECV;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, latched word count and address counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 16'd0;
            word_idx_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
        end
    end

    // Moore output decode; memory bus is driven only during the write cycle.
    always_comb begin
        in_ready  = (state_q == ST_RECV);
        mem_we    = (state_q == ST_WRITE);
        mem_a     = 32'h0;
        mem_wd    = 32'h0;
        busy      = (state_q == ST_RECV) || (state_q == ST_WRITE);
        done      = (state_q == ST_DONE);
        err       = (state_q == ST_ERR);
        cpu_reset = (state_q != ST_DONE);
        if (state_q == ST_WRITE) begin
            mem_a  = {14'h0, word_idx_q, 2'b00};
            mem_wd = asm_word;
        end
    end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_words = 16'd0;
    logic [7:0]  in_data = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, busy, done, err, cpu_reset;
    logic [31:0] mem_a, mem_wd;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int we_count = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    imem_loader #(.SIZE(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_words   (n_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write cycle seen on the memory bus.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_a);
            wd_q.push_back(mem_wd);
            we_count = we_count + 1;
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        we_count = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic start_load(input logic [15:0] n);
        start = 1'b1;
        n_words = n;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Offer bytes; a byte is consumed when in_valid and in_ready meet at an edge.
    task automatic send_bytes(input logic [7:0] b[$], input bit bubble);
        int i = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit acc;
        while (i < b.size() && guard < b.size() * 3 + 20) begin
            in_valid = bubble ? phase : 1'b1;
            in_data  = b[i];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
            phase = ~phase;
            guard++;
        end
        in_valid = 1'b0;
        vectors++;
        if (i != b.size()) begin
            miscompares++;
            $display("FAIL send_bytes: accepted %0d bytes, required %0d", i, b.size());
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, k);
        end
    endtask

    task automatic check_two_writes(input string tag);
        vectors++;
        if (wa_q.size() != 2 || we_count != 2) begin
            miscompares++;
            $display("FAIL %s_count: writes=%0d pulses=%0d, required 2", tag, wa_q.size(), we_count);
        end else begin
            vectors++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500513) begin
                miscompares++;
                $display("FAIL %s_w0: %h@%h, required 00500513@00000000", tag, wd_q[0], wa_q[0]);
            end
            vectors++;
            if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00B505B3) begin
                miscompares++;
                $display("FAIL %s_w1: %h@%h, required 00b505b3@00000004", tag, wd_q[1], wa_q[1]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({in_ready, mem_we, busy, done, err, cpu_reset} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy/we/busy/done/err/cpurst=%b, required 000001",
                     {in_ready, mem_we, busy, done, err, cpu_reset});
        end
        vectors++;
        if (mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bus: mem_a=%h mem_wd=%h, required 0 0", mem_a, mem_wd);
        end
    endtask

    task automatic test_two_word();
        logic [7:0] b[$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        clear_log();
        start_load(16'd2);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL two_word_recv: busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        send_bytes(b, 1'b0);
        wait_done(20);
        vectors++;
        if (cyc - start_cyc != 10) begin
            miscompares++;
            $display("FAIL two_word_latency: done after %0d cycles, required 10", cyc - start_cyc);
        end
        vectors++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL two_word_cpurst: cpu_reset=%b busy=%b, required 0 0", cpu_reset, busy);
        end
        check_two_writes("two_word");
    endtask

    task automatic test_bubbles();
        logic [7:0] b[$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        clear_log();
        start_load(16'd2);
        send_bytes(b, 1'b1);
        wait_done(40);
        check_two_writes("bubbles");
    endtask

    task automatic test_errors();
        logic [7:0] b[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        start_load(16'd0);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL err_zero: err=%b busy=%b cpu_reset=%b, required 1 0 1", err, busy, cpu_reset);
        end
        start_load(16'd1025);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_oversize: err=%b, required 1", err);
        end
        vectors++;
        if (we_count != 0) begin
            miscompares++;
            $display("FAIL err_no_write: pulses=%0d, required 0", we_count);
        end
        start_load(16'd1024);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL size_boundary: err=%b busy=%b, required 0 1", err, busy);
        end
        do_reset();
        start_load(16'd5);
        start_load(16'd1);
        vectors++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err_recover_sequence: err=%b in_ready=%b, required 0 1", err, in_ready);
        end
        do_reset();
        start_load(16'd0);
        start_load(16'd1);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err_recover: err=%b busy=%b in_ready=%b, required 0 1 1", err, busy, in_ready);
        end
        send_bytes(b, 1'b0);
        wait_done(10);
        vectors++;
        if (we_count != 1 || wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h44332211) begin
            miscompares++;
            $display("FAIL err_recover_write: pulses=%0d data=%h, required 1 44332211@0",
                     we_count, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] p[$] = '{8'h99, 8'h88};
        logic [7:0] b[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        start_load(16'd1);
        send_bytes(p, 1'b0);
        reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready, busy, done, err, cpu_reset} !== 5'b00001) begin
            miscompares++;
            $display("FAIL midword_async: rdy/busy/done/err/cpurst=%b, required 00001",
                     {in_ready, busy, done, err, cpu_reset});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (we_count != 0) begin
            miscompares++;
            $display("FAIL midword_no_write: pulses=%0d, required 0", we_count);
        end
        start_load(16'd1);
        send_bytes(b, 1'b0);
        wait_done(10);
        vectors++;
        if (we_count != 1 || wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDDCCBBAA) begin
            miscompares++;
            $display("FAIL midword_fresh: pulses=%0d, required 1 write of ddccbbaa@0", we_count);
        end
    endtask

    task automatic test_full_memory();
        logic [7:0] first[$];
        logic [7:0] rest[$];
        int bad = 0;
        logic [31:0] exp;
        for (int k = 0; k < 4096; k++) begin
            if (k < 10) first.push_back(8'((k * 7 + 3) & 255));
            else        rest.push_back(8'((k * 7 + 3) & 255));
        end
        clear_log();
        start_load(16'd1024);
        send_bytes(first, 1'b0);
        start = 1'b1;
        n_words = 16'd5;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_start_ignored: busy=%b err=%b, required 1 0", busy, err);
        end
        send_bytes(rest, 1'b0);
        wait_done(10);
        vectors++;
        if (wa_q.size() != 1024) begin
            miscompares++;
            $display("FAIL full_count: writes=%0d, required 1024", wa_q.size());
        end else begin
            for (int w = 0; w < 1024; w++) begin
                exp = 32'h0;
                for (int j = 3; j >= 0; j--) exp = {exp[23:0], 8'(((4 * w + j) * 7 + 3) & 255)};
                if (wa_q[w] !== 32'(w * 4) || wd_q[w] !== exp) bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL full_contents: %0d bad writes, required 0", bad);
            end
            vectors++;
            if (wa_q[1023] !== 32'hFFC) begin
                miscompares++;
                $display("FAIL full_last_addr: %h, required 00000ffc", wa_q[1023]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bubbles();
        test_errors();
        test_reset_mid_word();
        test_full_memory();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
